// File: rtl/tinyalu_cmd_seq.sv
// Command sequencer for the TinyALU: accepts one command at a time, drives the
// ALU, and queues each outcome (result, timeout or illegal-op error) in a response FIFO.
module tinyalu_cmd_seq #(
    parameter int TIMEOUT   = 16,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, COOL} state_t;

    state_t         state, state_next;
    logic [TW-1:0]  cnt;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [15:0]    mem_result [RSP_DEPTH];
    logic [2:0]     mem_op     [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] mem_err;

    logic           accept, push, pop, push_err;
    logic [15:0]    push_result;
    logic [2:0]     push_op;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A command is only taken when a FIFO slot is free, so the eventual push can never overflow.
    assign cmd_ready = reset_n && (state == IDLE) && (count < CW'(RSP_DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign alu_start = (state == RUN);
    assign busy      = (state != IDLE);
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_result = mem_result[rd_ptr];
    assign rsp_op     = mem_op[rd_ptr];
    assign rsp_err    = mem_err[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        push        = 1'b0;
        push_result = 16'h0000;
        push_err    = 1'b0;
        push_op     = alu_op;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op >= 3'd1 && cmd_op <= 3'd4) begin
                        state_next = RUN;
                    end else begin
                        // No-op and illegal ops answer immediately without touching the ALU.
                        state_next = COOL;
                        push       = 1'b1;
                        push_op    = cmd_op;
                        push_err   = (cmd_op != 3'd0);
                    end
                end
            end
            RUN: begin
                if (alu_done) begin
                    state_next  = COOL;
                    push        = 1'b1;
                    push_result = alu_result;
                end else if (cnt == TW'(TIMEOUT - 1)) begin
                    state_next  = COOL;
                    push        = 1'b1;
                    push_result = 16'hFFFF;
                    push_err    = 1'b1;
                end
            end
            COOL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counts RUN cycles; it sits at zero outside RUN so it is clear on entry.
    always_ff @(posedge clk) begin
        if (!reset_n || state != RUN) cnt <= '0;
        else                          cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_A  <= 8'h00;
            alu_B  <= 8'h00;
            alu_op <= 3'd0;
        end else if (accept) begin
            alu_A  <= cmd_a;
            alu_B  <= cmd_b;
            alu_op <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            mem_err <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_result[i] <= 16'h0000;
                mem_op[i]     <= 3'd0;
            end
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= push_result;
                mem_op[wr_ptr]     <= push_op;
                mem_err[wr_ptr]    <= push_err;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_cmd_seq.sv
// Directed bench for tinyalu_cmd_seq: drives commands and ALU completions, and
// checks every response against a scoreboard queue of expected {result, op, err}.
module tb_tinyalu_cmd_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic [7:0]  alu_A, alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];

    tinyalu_cmd_seq #(.TIMEOUT(16), .RSP_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: compare each response as it is handed over
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_rsp observed=%0h expected=none", {rsp_result, rsp_op, rsp_err});
            end
            if (exp_q.size() != 0) check("rsp", {12'h0, rsp_result, rsp_op, rsp_err}, {12'h0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        step();
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        cmd_valid = 1'b0;
        check("cmd_accept", {31'h0, ok}, 32'h1);
    endtask

    // Raise alu_done for one cycle, w cycles after the first start cycle.
    task automatic finish_alu(input int w, input logic [15:0] res);
        repeat (w) step();
        alu_done = 1'b1; alu_result = res;
        step();
        alu_done = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        // reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_alu_start", {31'h0, alu_start}, 0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'h0, cmd_ready}, 1);
        rsp_ready = 1'b1;

        // ADD
        send(3'd1, 8'h12, 8'h34);
        exp_q.push_back({16'h0046, 3'd1, 1'b0});
        @(negedge clk);
        check("add_start", {31'h0, alu_start}, 1);
        check("add_operands", {13'h0, alu_op, alu_A, alu_B}, {13'h0, 3'd1, 8'h12, 8'h34});
        finish_alu(1, 16'h0046);
        @(negedge clk);
        check("add_start_low", {31'h0, alu_start}, 0);
        check("add_rsp_valid", {31'h0, rsp_valid}, 1);
        drain();

        // MUL
        send(3'd4, 8'hFF, 8'hFF);
        exp_q.push_back({16'hFE01, 3'd4, 1'b0});
        @(negedge clk);
        check("mul_busy_run", {31'h0, busy}, 1);
        finish_alu(3, 16'hFE01);
        @(negedge clk);
        check("mul_busy_cool", {31'h0, busy}, 1);
        check("mul_start_cool", {31'h0, alu_start}, 0);
        step();
        @(negedge clk);
        check("mul_idle", {31'h0, busy}, 0);
        drain();

        // TIMEOUT: sixteen RUN cycles, then an error response
        send(3'd2, 8'h01, 8'h02);
        exp_q.push_back({16'hFFFF, 3'd2, 1'b1});
        repeat (15) step();
        @(negedge clk);
        check("to_run16_start", {31'h0, alu_start}, 1);
        check("to_run16_no_rsp", {31'h0, rsp_valid}, 0);
        step();
        @(negedge clk);
        check("to_cool_start", {31'h0, alu_start}, 0);
        check("to_rsp_valid", {31'h0, rsp_valid}, 1);
        step();
        alu_done = 1'b1; alu_result = 16'h1234;
        repeat (2) step();
        alu_done = 1'b0;
        @(negedge clk);
        check("late_done_ignored", {31'h0, rsp_valid}, 0);
        check("late_done_busy", {31'h0, busy}, 0);
        drain();

        // FULL: four responses held back, fifth command stalls
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(3'd1, 8'(i + 1), 8'(i + 1));
            exp_q.push_back({16'(2 * (i + 1)), 3'd1, 1'b0});
            finish_alu(1, 16'(2 * (i + 1)));
        end
        step();
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h05; cmd_b = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_cmd_ready", {31'h0, cmd_ready}, 0);
            check("full_no_start", {31'h0, alu_start}, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("full_pop_ready", {31'h0, cmd_ready}, 1);
        step();
        cmd_valid = 1'b0;
        exp_q.push_back({16'h000A, 3'd1, 1'b0});
        finish_alu(1, 16'h000A);
        rsp_ready = 1'b1;
        drain();

        // ILLEGAL / NOP
        send(3'd0, 8'hAA, 8'h55);
        exp_q.push_back({16'h0000, 3'd0, 1'b0});
        @(negedge clk);
        check("nop_no_start", {31'h0, alu_start}, 0);
        check("nop_busy", {31'h0, busy}, 1);
        send(3'd6, 8'h11, 8'h22);
        exp_q.push_back({16'h0000, 3'd6, 1'b1});
        @(negedge clk);
        check("ill_no_start", {31'h0, alu_start}, 0);
        drain();

        // RESET-MID-RUN
        send(3'd4, 8'h03, 8'h07);
        @(negedge clk);
        check("rmr_running", {31'h0, alu_start}, 1);
        step();
        reset_n = 1'b0;
        @(negedge clk);
        check("rmr_cmd_ready_rst", {31'h0, cmd_ready}, 0);
        step();
        reset_n = 1'b1;
        alu_done = 1'b1; alu_result = 16'h5555;
        @(negedge clk);
        check("rmr_outputs", {alu_start, busy, rsp_valid, alu_op, alu_A, alu_B},
              {1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00});
        check("rmr_rsp_fields", {12'h0, rsp_result, rsp_op, rsp_err}, 32'h0);
        check("rmr_cmd_ready", {31'h0, cmd_ready}, 1);
        step();
        alu_done = 1'b0;
        @(negedge clk);
        check("rmr_done_ignored", {31'h0, rsp_valid}, 0);
        send(3'd3, 8'h0F, 8'hF0);
        exp_q.push_back({16'h00FF, 3'd3, 1'b0});
        finish_alu(2, 16'h00FF);
        drain();

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
